pmem_responder: RTL and testbench

Line-granular physical-memory responder that sits on the far side of the cache's pmem port. It accepts 128-bit line reads and writes from the cache, waits a programmable number of cycles, then commits or returns the line with a one-cycle `pmem_resp` pulse. It is the synthesizable memory model the cache datapath/control pair is simulated and FPGA-tested against, and it replaces the behavioural testbench memory.

---
 rtl/pmem_responder_pkg.sv | 23 ++
 rtl/pmem_responder_if.sv | 30 +++
 rtl/pmem_responder_line_array.sv | 22 ++
 rtl/pmem_responder.sv | 129 ++++++++++++
 tb/tb_pmem_responder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared LC-3b types plus the pmem responder state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2,
      RESP = 2'd3
   } pmem_state_t;

   // True when the live request no longer matches the latched op.
   function automatic logic op_flip(
      input logic op_wr,
      input logic rd,
      input logic wr
   );
      return op_wr ? (rd && !wr) : wr;
   endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-side pmem line port: held read/write request, one-cycle response.
interface pmem_responder_if;
   import lc3b_types::*;

   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;

   modport master (
      output pmem_read,
      output pmem_write,
      output pmem_address,
      output pmem_wdata,
      input  pmem_rdata,
      input  pmem_resp
   );

   modport slave (
      input  pmem_read,
      input  pmem_write,
      input  pmem_address,
      input  pmem_wdata,
      output pmem_rdata,
      output pmem_resp
   );

endinterface

// File: rtl/pmem_responder_line_array.sv
// Single-port line store: synchronous write, combinational read.
module pmem_line_array
   import lc3b_types::*;
#(
   parameter int LINES_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LINES_LOG2-1:0] addr,
   input  lc3b_line              wdata,
   output lc3b_line              rdata
);

   lc3b_line mem [1 << LINES_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical memory responder with programmable latency.
module pmem_responder
   import lc3b_types::*;
#(
   parameter int LATENCY    = 4,
   parameter int LINES_LOG2 = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   pmem_responder_if.slave  pmem,
   output logic             init_done,
   output logic             protocol_err
);

   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [LINES_LOG2-1:0] LAST = LINES_LOG2'((1 << LINES_LOG2) - 1);

   pmem_state_t           state;
   logic [CW-1:0]         cnt;
   logic [LINES_LOG2-1:0] sweep;
   logic [LINES_LOG2-1:0] idx;
   logic [LINES_LOG2-1:0] req_idx;
   logic [LINES_LOG2-1:0] arr_addr;
   logic                  op_wr;
   lc3b_line              wbuf;
   lc3b_line              rdata_q;
   lc3b_line              arr_wdata;
   lc3b_line              arr_rdata;
   logic                  arr_we;
   logic                  req;
   logic                  flip;
   logic                  resp;
   logic                  unused_addr;

   assign req = pmem.pmem_read | pmem.pmem_write;
   assign req_idx = pmem.pmem_address[LINES_LOG2+3:4];
   assign flip = op_flip(op_wr, pmem.pmem_read, pmem.pmem_write);
   // Dropping the request in RESP must kill the pulse in the same cycle.
   assign resp = (state == RESP) & req;
   assign pmem.pmem_resp = resp;
   assign pmem.pmem_rdata = rdata_q;
   assign unused_addr = ^{pmem.pmem_address[15:LINES_LOG2+4],
                          pmem.pmem_address[3:0]};

   always_comb begin
      arr_we = 1'b0;
      arr_addr = idx;
      arr_wdata = wbuf;
      unique case (state)
         INIT: begin
            arr_we = 1'b1;
            arr_addr = sweep;
            arr_wdata = '0;
         end
         IDLE: arr_addr = req_idx;
         RESP: arr_we = resp & op_wr;
         BUSY: arr_addr = idx;
      endcase
   end

   pmem_line_array #(
      .LINES_LOG2(LINES_LOG2)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT;
         cnt <= '0;
         sweep <= '0;
         idx <= '0;
         op_wr <= 1'b0;
         wbuf <= '0;
         rdata_q <= '0;
         init_done <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               sweep <= sweep + 1'b1;
               if (sweep == LAST) begin
                  init_done <= 1'b1;
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (req) begin
                  op_wr <= pmem.pmem_write;
                  idx <= req_idx;
                  wbuf <= pmem.pmem_wdata;
                  cnt <= CNT_LOAD;
                  if (pmem.pmem_read && pmem.pmem_write)
                     protocol_err <= 1'b1;
                  if (CNT_LOAD == '0) begin
                     state <= RESP;
                     if (!pmem.pmem_write) rdata_q <= arr_rdata;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!req) begin
                  state <= IDLE;
               end else begin
                  if (flip) protocol_err <= 1'b1;
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     state <= RESP;
                     if (!op_wr) rdata_q <= arr_rdata;
                  end
               end
            end
            RESP: begin
               if (req && flip) protocol_err <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench: transaction-level memory model plus directed pins.
module tb_pmem_responder;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pmem_responder_if bus ();
   pmem_responder_if bus1 ();

   logic init_done, perr, init_done1, perr1;

   pmem_responder #(.LATENCY(LAT), .LINES_LOG2(5)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem         (bus),
      .init_done    (init_done),
      .protocol_err (perr)
   );

   pmem_responder #(.LATENCY(1), .LINES_LOG2(5)) dut1 (
      .clk          (clk),
      .reset_n      (reset_n),
      .pmem         (bus1),
      .init_done    (init_done1),
      .protocol_err (perr1)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rel_base = 0;
   bit in_reset = 1'b1;
   int exp_resp_cyc = -1;
   logic [127:0] rhold = '0;
   bit perr_m = 1'b0;
   logic [127:0] mem_m [32];

   always @(posedge clk) cyc++;

   task automatic chk(input string n, input logic [127:0] got,
                      input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (in_reset) begin
         chk("rst_resp", 128'(bus.pmem_resp), 128'(0));
         chk("rst_rdata", bus.pmem_rdata, 128'(0));
         chk("rst_init", 128'(init_done), 128'(0));
         chk("rst_perr", 128'(perr), 128'(0));
      end else begin
         chk("resp", 128'(bus.pmem_resp), 128'(cyc == exp_resp_cyc));
         chk("rdata", bus.pmem_rdata, rhold);
         chk("init_done", 128'(init_done), 128'((cyc - rel_base) >= 32));
         chk("perr", 128'(perr), 128'(perr_m));
      end
   end

   task automatic do_reset(input int hold);
      reset_n = 1'b0;
      in_reset = 1'b1;
      bus.pmem_read = 1'b0;
      bus.pmem_write = 1'b0;
      bus1.pmem_read = 1'b0;
      bus1.pmem_write = 1'b0;
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      rhold = '0;
      perr_m = 1'b0;
      exp_resp_cyc = -1;
      repeat (hold) @(posedge clk);
      #1;
      reset_n = 1'b1;
      in_reset = 1'b0;
      rel_base = cyc;
      repeat (31) @(posedge clk);
      @(negedge clk);
      chk("init_lo_31", 128'(init_done), 128'(0));
      @(posedge clk);
      @(negedge clk);
      chk("init_hi_32", 128'(init_done), 128'(1));
      @(posedge clk);
      #1;
   endtask

   // Called at #1 into an IDLE cycle; returns at #1 into the next IDLE cycle.
   task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [127:0] d, input int k_abort,
                      input bit flip, output logic [127:0] got_rd,
                      output bit got_resp);
      int line;
      int acc;
      int n;
      line = int'(addr[8:4]);
      bus.pmem_read = rd;
      bus.pmem_write = wr;
      bus.pmem_address = addr;
      bus.pmem_wdata = d;
      acc = cyc;
      exp_resp_cyc = (k_abort == 0) ? acc + LAT : -1;
      n = (k_abort == 0) ? LAT : k_abort;
      got_resp = 1'b0;
      got_rd = '0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            if (rd && wr) perr_m = 1'b1;
            bus.pmem_address = 16'($urandom);
            bus.pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            if (flip) begin
               bus.pmem_read = 1'b0;
               bus.pmem_write = 1'b1;
            end
         end
         if (flip && i == 2) perr_m = 1'b1;
         if (i == LAT && !wr) rhold = mem_m[line];
      end
      if (k_abort != 0) begin
         bus.pmem_read = 1'b0;
         bus.pmem_write = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         @(negedge clk);
         got_resp = bus.pmem_resp;
         got_rd = bus.pmem_rdata;
         if (wr) mem_m[line] = d;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      bus.pmem_read = 1'b0;
      bus.pmem_write = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [127:0] g;
   bit r;
   logic [127:0] p1, p2, p3, p4, p5;

   initial begin
      bus.pmem_read = 1'b0;
      bus.pmem_write = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata = '0;
      bus1.pmem_read = 1'b0;
      bus1.pmem_write = 1'b0;
      bus1.pmem_address = '0;
      bus1.pmem_wdata = '0;
      p1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      p2 = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;
      p3 = 128'hffff_0000_ffff_0000_a5a5_5a5a_0f0f_f0f0;
      p4 = 128'h3030_3030_c3c3_c3c3_0000_0001_8000_0000;
      p5 = 128'h0040_0040_0040_0040_5555_aaaa_5555_aaaa;
      @(posedge clk);
      #1;
      do_reset(2);

      txn(1, 0, 16'h0000, '0, 0, 0, g, r);
      chk("rd0_resp", 128'(r), 128'(1));
      chk("rd0_data", g, 128'(0));
      idle(1);

      txn(0, 1, 16'h0120, p1, 0, 0, g, r);
      chk("wr120_resp", 128'(r), 128'(1));
      txn(1, 0, 16'h0120, '0, 0, 0, g, r);
      chk("rd120_data", g, p1);
      idle(2);
      txn(1, 0, 16'h012c, '0, 0, 0, g, r);
      chk("rd12c_data", g, p1);
      idle(1);

      txn(0, 1, 16'h0200, p2, 0, 0, g, r);
      idle(1);
      txn(1, 0, 16'h0000, '0, 0, 0, g, r);
      chk("alias_data", g, p2);
      idle(1);

      txn(1, 0, 16'h0050, '0, 0, 1, g, r);
      chk("flip_resp", 128'(r), 128'(1));
      idle(1);
      chk("flip_perr", 128'(perr), 128'(1));

      txn(0, 1, 16'h0120, p3, 2, 0, g, r);
      txn(1, 0, 16'h0120, '0, 0, 0, g, r);
      chk("abort_keep", g, p1);
      idle(1);

      bus.pmem_write = 1'b1;
      bus.pmem_address = 16'h0300;
      bus.pmem_wdata = p3;
      @(posedge clk);
      #1;
      do_reset(2);
      chk("rst_perr_clr", 128'(perr), 128'(0));
      txn(1, 0, 16'h0120, '0, 0, 0, g, r);
      chk("rst_recleared", g, 128'(0));
      idle(1);

      txn(1, 1, 16'h0030, p4, 0, 0, g, r);
      idle(1);
      chk("both_perr", 128'(perr), 128'(1));
      txn(1, 0, 16'h0030, '0, 0, 0, g, r);
      chk("both_wrote", g, p4);
      idle(3);
      chk("both_sticky", 128'(perr), 128'(1));

      for (int i = 0; i < 400; i++) begin
         int op;
         int ab;
         bit rd;
         bit wr;
         op = int'($urandom_range(0, 19));
         rd = (op <= 9);
         wr = (op == 0) || (op >= 10);
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LAT)) : 0;
         if (i == 200) do_reset(3);
         txn(rd, wr, 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
             ab, 0, g, r);
         if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
      end
      idle(1);

      bus1.pmem_write = 1'b1;
      bus1.pmem_address = 16'h0040;
      bus1.pmem_wdata = p5;
      @(negedge clk);
      chk("lat1_wr_wait", 128'(bus1.pmem_resp), 128'(0));
      @(posedge clk);
      @(negedge clk);
      chk("lat1_wr_resp", 128'(bus1.pmem_resp), 128'(1));
      @(posedge clk);
      #1;
      bus1.pmem_write = 1'b0;
      bus1.pmem_read = 1'b1;
      @(negedge clk);
      chk("lat1_rd_wait", 128'(bus1.pmem_resp), 128'(0));
      @(posedge clk);
      @(negedge clk);
      chk("lat1_rd_resp", 128'(bus1.pmem_resp), 128'(1));
      chk("lat1_rd_data", bus1.pmem_rdata, p5);
      @(posedge clk);
      #1;
      bus1.pmem_read = 1'b0;
      chk("lat1_perr", 128'(perr1), 128'(0));
      chk("lat1_init", 128'(init_done1), 128'(1));

      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
